// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm bank: FSM state encoding, time field widths,
// and the snooze-target arithmetic.
package alarm_pkg;

    localparam int unsigned HR_MAX  = 23;
    localparam int unsigned MIN_MAX = 59;
    localparam int unsigned HR_W    = 5;
    localparam int unsigned MIN_W   = 6;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRing   = 2'd1,
        StSnooze = 2'd2
    } alarm_state_e;

    typedef struct packed {
        logic [HR_W-1:0]  hour;
        logic [MIN_W-1:0] minute;
    } hhmm_t;

    // Adds at most 59 minutes to a time of day, carrying into the hour and past midnight.
    function automatic hhmm_t add_minutes(hhmm_t t, int unsigned mins);
        hhmm_t       r;
        int unsigned m;
        int unsigned h;
        m = 32'(t.minute) + mins;
        h = 32'(t.hour);
        if (m > MIN_MAX) begin
            m = m - (MIN_MAX + 1);
            h = (h == HR_MAX) ? 32'd0 : h + 32'd1;
        end
        r.hour   = HR_W'(h);
        r.minute = MIN_W'(m);
        return r;
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored hour/minute/armed setting, wrap-around field increment and
// comparison of the setting against the current time.
module alarm_channel
    import alarm_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             set_min_i,
    input  logic             arm_toggle_i,
    input  logic [HR_W-1:0]  cur_hour_i,
    input  logic [MIN_W-1:0] cur_min_i,
    output logic [HR_W-1:0]  hour_o,
    output logic [MIN_W-1:0] minute_o,
    output logic             armed_o,
    output logic             match_o
);

    logic [HR_W-1:0]  hour_q, hour_d;
    logic [MIN_W-1:0] minute_q, minute_d;
    logic             armed_q, armed_d;

    // Fields wrap independently; a minute rollover never carries into the hour.
    always_comb begin
        hour_d   = hour_q;
        minute_d = minute_q;
        armed_d  = armed_q ^ arm_toggle_i;
        if (inc_i) begin
            if (set_min_i) begin
                minute_d = (minute_q == MIN_W'(MIN_MAX)) ? '0 : minute_q + 1'b1;
            end else begin
                hour_d = (hour_q == HR_W'(HR_MAX)) ? '0 : hour_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hour_q   <= '0;
            minute_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            hour_q   <= hour_d;
            minute_q <= minute_d;
            armed_q  <= armed_d;
        end
    end

    assign hour_o   = hour_q;
    assign minute_o = minute_q;
    assign armed_o  = armed_q;
    assign match_o  = armed_q && (hour_q == cur_hour_i) && (minute_q == cur_min_i);

endmodule

// File: rtl/alarm_bank.sv
// Bank of N_ALARM alarm channels sharing one ring/snooze controller with auto-stop,
// limited snoozes and an intermittent beep drive.
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int unsigned N_ALARM    = 4,
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned MAX_SNOOZE = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sec_tick,
    input  logic [HR_W-1:0]            hour,
    input  logic [MIN_W-1:0]           minute,
    input  logic [MIN_W-1:0]           second,
    input  logic [$clog2(N_ALARM)-1:0] sel,
    input  logic                       edit_en,
    input  logic                       set_hr_or_min,
    input  logic                       inc_short,
    input  logic                       arm_toggle,
    input  logic                       snooze,
    input  logic                       dismiss,
    output logic [HR_W-1:0]            hour_out,
    output logic [MIN_W-1:0]           minute_out,
    output logic                       armed_out,
    output logic                       beep_out,
    output logic [$clog2(N_ALARM)-1:0] active_ch,
    output logic                       ringing
);

    localparam int unsigned SelW  = $clog2(N_ALARM);
    localparam int unsigned RingW = $clog2(RING_SEC + 1);
    localparam int unsigned SnzW  = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);

    logic [HR_W-1:0]    ch_hour [N_ALARM];
    logic [MIN_W-1:0]   ch_min  [N_ALARM];
    logic [N_ALARM-1:0] ch_armed;
    logic [N_ALARM-1:0] ch_match;

    alarm_state_e    state_q, state_d;
    logic [RingW-1:0] ring_cnt_q, ring_cnt_d;
    logic [SnzW-1:0]  snooze_cnt_q, snooze_cnt_d;
    hhmm_t           target_q, target_d;
    logic [SelW-1:0] active_ch_q, active_ch_d;
    logic            beep_q, beep_d;
    logic            ringing_q, ringing_d;

    logic            any_match;
    logic [SelW-1:0] match_idx;
    logic            act_armed;
    hhmm_t           now_t;
    logic            top_of_min;
    logic            at_target;
    logic            ring_last;
    logic            snooze_ok;

    for (genvar i = 0; i < N_ALARM; i++) begin : g_ch
        logic sel_hit;
        assign sel_hit = (sel == SelW'(i));

        alarm_channel u_ch (
            .clk_i        (clk),
            .rst_i        (rst),
            .inc_i        (edit_en && inc_short && sel_hit),
            .set_min_i    (set_hr_or_min),
            .arm_toggle_i (arm_toggle && sel_hit),
            .cur_hour_i   (hour),
            .cur_min_i    (minute),
            .hour_o       (ch_hour[i]),
            .minute_o     (ch_min[i]),
            .armed_o      (ch_armed[i]),
            .match_o      (ch_match[i])
        );
    end

    // Display path: selected channel setting, combinational from sel.
    always_comb begin
        hour_out   = '0;
        minute_out = '0;
        armed_out  = 1'b0;
        for (int i = 0; i < N_ALARM; i++) begin
            if (sel == SelW'(i)) begin
                hour_out   = ch_hour[i];
                minute_out = ch_min[i];
                armed_out  = ch_armed[i];
            end
        end
    end

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        any_match = 1'b0;
        match_idx = '0;
        for (int i = N_ALARM - 1; i >= 0; i--) begin
            if (ch_match[i]) begin
                any_match = 1'b1;
                match_idx = SelW'(i);
            end
        end
    end

    always_comb begin
        act_armed = 1'b0;
        for (int i = 0; i < N_ALARM; i++) begin
            if (active_ch_q == SelW'(i)) begin
                act_armed = ch_armed[i];
            end
        end
    end

    assign now_t      = {hour, minute};
    assign top_of_min = sec_tick && (second == '0);
    assign at_target  = (now_t == target_q);
    assign ring_last  = (ring_cnt_q == RingW'(RING_SEC - 1));
    assign snooze_ok  = (snooze_cnt_q < SnzW'(MAX_SNOOZE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority within each state: dismiss, then snooze, then timeout, then match.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (top_of_min && any_match) begin
                    state_d = StRing;
                end
            end
            StRing: begin
                if (dismiss) begin
                    state_d = StIdle;
                end else if (snooze) begin
                    state_d = snooze_ok ? StSnooze : StIdle;
                end else if (sec_tick && ring_last) begin
                    state_d = StIdle;
                end
            end
            StSnooze: begin
                if (dismiss || !act_armed) begin
                    state_d = StIdle;
                end else if (top_of_min && at_target) begin
                    state_d = StRing;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Counters, snooze target and registered outputs, keyed on the state transition.
    always_comb begin
        ring_cnt_d   = ring_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        target_d     = target_q;
        active_ch_d  = active_ch_q;
        beep_d       = beep_q;
        if (state_q == StIdle && state_d == StRing) begin
            active_ch_d  = match_idx;
            ring_cnt_d   = '0;
            snooze_cnt_d = '0;
            beep_d       = 1'b1;
        end else if (state_q == StRing && state_d == StRing) begin
            if (sec_tick) begin
                ring_cnt_d = ring_cnt_q + 1'b1;
                beep_d     = ~beep_q;
            end
        end else if (state_q == StRing && state_d == StSnooze) begin
            target_d     = add_minutes(now_t, SNOOZE_MIN);
            snooze_cnt_d = snooze_cnt_q + 1'b1;
        end else if (state_q == StSnooze && state_d == StRing) begin
            ring_cnt_d = '0;
            beep_d     = 1'b1;
        end
        if (state_d != StRing) begin
            beep_d = 1'b0;
        end
        ringing_d = (state_d == StRing);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ring_cnt_q   <= '0;
            snooze_cnt_q <= '0;
            target_q     <= '0;
            active_ch_q  <= '0;
            beep_q       <= 1'b0;
            ringing_q    <= 1'b0;
        end else begin
            ring_cnt_q   <= ring_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            target_q     <= target_d;
            active_ch_q  <= active_ch_d;
            beep_q       <= beep_d;
            ringing_q    <= ringing_d;
        end
    end

    assign beep_out  = beep_q;
    assign active_ch = active_ch_q;
    assign ringing   = ringing_q;

endmodule
